handshake_fifo: RTL and testbench

- Elastic buffer placed directly downstream of an arf output port (dout_req_N/dout_ack_N/dout_N) and upstream of a consumer.
- Its upstream side acts as a consumer: it drives req_l and captures din on ack_l.
- Its downstream side acts as a producer: it answers req_r with a one-cycle ack_r pulse plus registered dout.
- Decouples arf throughput from consumer stalls and reports occupancy and overflow for throughput benches.

---
 rtl/handshake_fifo.sv | 79 +++++++
 tb/tb_handshake_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo.sv
// Elastic buffer between an arf output port (req_l/ack_l/din) and a downstream
// consumer (req_r/ack_r/dout); all outputs registered, occupancy and sticky overflow reported.
module handshake_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   occupancy,
  output logic                  overflow
);

  localparam logic [addr_width:0] OCC_FULL    = (addr_width+1)'(depth);
  localparam logic [addr_width:0] OCC_REQ_MAX = (addr_width+1)'(depth - 2);

  logic [data_width-1:0] mem_q [depth];

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   occ_q, occ_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic                  ovf_q, ovf_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  wr_en, rd_en;

  always_comb begin
    wr_en    = ack_l && (occ_q != OCC_FULL);
    rd_en    = req_r && !ack_r_q && (occ_q != '0);
    wr_ptr_d = wr_en ? wr_ptr_q + addr_width'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + addr_width'(1) : rd_ptr_q;
    occ_d    = occ_q + (addr_width+1)'(wr_en) - (addr_width+1)'(rd_en);
    // One slot of margin absorbs an ack already in flight from the producer.
    req_l_d  = (occ_d <= OCC_REQ_MAX);
    ack_r_d  = rd_en;
    dout_d   = rd_en ? mem_q[rd_ptr_q] : dout_q;
    ovf_d    = ovf_q | (ack_l && (occ_q == OCC_FULL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      req_l_q  <= 1'b0;
      ack_r_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      req_l_q  <= req_l_d;
      ack_r_q  <= ack_r_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign req_l     = req_l_q;
  assign ack_r     = ack_r_q;
  assign dout      = dout_q;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized self-checking bench for handshake_fifo against a queue-based reference model.
module tb_handshake_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_l;
  logic          ack_l;
  logic [DW-1:0] din;
  logic          req_r;
  logic          ack_r;
  logic [DW-1:0] dout;
  logic [AW:0]   occupancy;
  logic          overflow;

  handshake_fifo #(.data_width(DW), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_l     (req_l),
    .ack_l     (ack_l),
    .din       (din),
    .req_r     (req_r),
    .ack_r     (ack_r),
    .dout      (dout),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the buffer is just a queue; outputs follow the handshake rules.
  logic [DW-1:0] m_q [$];
  logic          m_ack_r = 1'b0;
  logic [DW-1:0] m_dout  = '0;
  logic          m_ovf   = 1'b0;
  logic          m_req_l = 1'b0;

  logic [DW-1:0] seq = '0;
  logic          prev_ack = 1'b0;

  task automatic step(input logic r, input logic al, input logic [DW-1:0] d, input logic rr);
    int unsigned sz0;
    logic rd;
    rst = r; ack_l = al; din = d; req_r = rr;
    prev_ack = al;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ack_r = 1'b0; m_dout = '0; m_ovf = 1'b0; m_req_l = 1'b0;
    end else begin
      sz0 = m_q.size();
      rd  = rr && !m_ack_r && (sz0 > 0);
      if (rd) m_dout = m_q.pop_front();
      m_ack_r = rd;
      if (al) begin
        if (sz0 >= DEPTH) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
      m_req_l = (m_q.size() <= DEPTH - 2);
    end
    #1;
    chk("occupancy", DW'(occupancy), DW'(m_q.size()));
    chk("req_l", DW'(req_l), DW'(m_req_l));
    chk("ack_r", DW'(ack_r), DW'(m_ack_r));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("dout", dout, m_dout);
  endtask

  // Compliant producer: acks only on req & ~ack, optionally skipping at fail% rate.
  task automatic prod_step(input int unsigned fail, input logic rr);
    logic al;
    al = req_l && !prev_ack && ($urandom_range(99) >= fail);
    step(1'b0, al, seq, rr);
    if (al) seq++;
  endtask

  initial begin
    int unsigned got_cnt;
    int unsigned cyc;
    int unsigned last_cyc;
    logic [DW-1:0] exp_val;

    rst = 1'b1; ack_l = 1'b0; din = '0; req_r = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h55, 1'b1);
    chk("rst_occ", DW'(occupancy), '0);
    chk("rst_req_l", DW'(req_l), '0);

    // Fill with consumer stalled
    for (int i = 0; i < 14; i++) prod_step(0, 1'b0);
    chk("fill_occ", DW'(occupancy), DW'(DEPTH - 1));
    chk("fill_req_l", DW'(req_l), '0);
    chk("fill_ovf", DW'(overflow), '0);

    // Drain while producer keeps feeding; consumer sees 0,1,2,... in order
    exp_val = '0;
    for (int i = 0; i < 40; i++) begin
      prod_step(0, 1'b1);
      if (ack_r) begin chk("drain_seq", dout, exp_val); exp_val++; end
    end

    // Random compliant traffic: simultaneous push/pop and pointer wraps
    for (int i = 0; i < 600; i++) prod_step($urandom_range(60), 1'($urandom_range(1)));

    // Overflow: forced producer, consumer stalled
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, seq, 1'b0);
      seq++;
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hAA, 1'b0);
    chk("ovf_occ", DW'(occupancy), DW'(DEPTH));
    chk("ovf_flag", DW'(overflow), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'hAA, 1'b1);
      if (ack_r && dout == 32'hAA) chk("ovf_no_aa", dout, seq);
    end
    chk("ovf_sticky", DW'(overflow), 32'd1);

    // Random non-compliant producer
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
    end

    // Reset mid-operation, with a coincident ack_l
    for (int i = 0; i < 10; i++) prod_step(0, 1'b0);
    for (int i = 0; i < 3; i++) prod_step(0, 1'b1);
    step(1'b1, 1'b1, 32'hDEAD, 1'b1);
    chk("mid_rst_occ", DW'(occupancy), '0);
    chk("mid_rst_ovf", DW'(overflow), '0);
    prev_ack = 1'b0;
    seq = 32'h1000;
    exp_val = 32'h1000;
    got_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      prod_step(0, 1'b1);
      if (ack_r && got_cnt == 0) begin chk("post_rst_first", dout, exp_val); got_cnt++; end
    end
    chk("post_rst_seen", got_cnt, 32'd1);

    // Throughput: 5000 items, no stalls on either side
    step(1'b1, 1'b0, '0, 1'b0);
    prev_ack = 1'b0;
    seq = '0; exp_val = '0; got_cnt = 0; cyc = 0; last_cyc = 0;
    while (got_cnt < 5000 && cyc < 12000) begin
      prod_step(0, 1'b1);
      cyc++;
      if (ack_r) begin
        if (dout !== exp_val) chk("tput_seq", dout, exp_val);
        exp_val++; got_cnt++; last_cyc = cyc;
      end
    end
    chk("tput_count", got_cnt, 32'd5000);
    n_checks++;
    if (last_cyc > 2 * 5000 + 4) begin
      n_errors++;
      $display("FAIL tput_rate: got %0d cycles required <= %0d", last_cyc, 2 * 5000 + 4);
    end
    chk("tput_ovf", DW'(overflow), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
